// File: rtl/alpha_pkg.sv
// Shared constants for the alphanumeric display path.
//   ALPHA_BLANK  code that drives the 14-segment decoder dark
//   ALPHA_MAX    highest valid letter code (Z)
//   ST_*         scroller state encoding
//   alpha_norm   maps out-of-range codes onto ALPHA_BLANK
package alpha_pkg;

    localparam logic [4:0] ALPHA_BLANK = 5'd31;
    localparam logic [4:0] ALPHA_MAX   = 5'd25;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_SCROLL = 2'd3;

    function automatic logic [4:0] alpha_norm(input logic [4:0] code);
        return (code > ALPHA_MAX) ? ALPHA_BLANK : code;
    endfunction

endpackage

// File: rtl/alpha_tick_gen.sv
// Character hold timer: a down-counter that reloads to TICK_DIV-1 and
// raises tick for one cycle when it reaches zero while enabled.
//   clk      system clock
//   rst      synchronous active-high reset
//   en       count enable
//   restart  reload the counter so the next tick is a full period away
//   tick     one-cycle pulse every TICK_DIV enabled cycles
module alpha_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !restart && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= LOAD_VAL;
        end else if (restart || tick) begin
            cnt <= LOAD_VAL;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alpha_scroller.sv
// Message sequencer feeding the 14-segment alphadecode stage. Stores a
// message of letter codes and presents them one at a time, each held for
// TICK_DIV clocks, wrapping back to the first character.
//   clk, rst                 clock, synchronous active-high reset
//   clr                      discard the message, back to EMPTY
//   wr_valid/wr_ready        character write handshake
//   wr_code, wr_last         letter code and end-of-message marker
//   start, stop              scroll control (stop wins)
//   a..e                     current code to the decoder, a = MSB
//   blank, busy, wrap        dark display, scrolling, return-to-first pulse
//
// state     | meaning
// ST_EMPTY  | no message, waiting for the first character
// ST_LOAD   | collecting characters until wr_last or buffer full
// ST_READY  | message held, display dark, waiting for start
// ST_SCROLL | cycling through the message
module alpha_scroller
    import alpha_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_code,
    input  logic       wr_last,
    input  logic       start,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       blank,
    output logic       busy,
    output logic       wrap
);

    localparam int            IW       = $clog2(MSG_DEPTH) + 1;
    localparam int            AW       = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_DEPTH - 1);

    logic [4:0]    msg_buf [MSG_DEPTH];
    logic [1:0]    state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [IW-1:0] len, len_n;
    logic [4:0]    code_q;
    logic [4:0]    cur_code;
    logic          wr_en, restart, tick, wrap_n;

    alpha_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_SCROLL),
        .restart (restart),
        .tick    (tick)
    );

    // idx doubles as the write pointer while loading and the display
    // position while scrolling; it is zero whenever neither applies.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len;
        wr_en   = 1'b0;
        restart = 1'b0;
        wrap_n  = 1'b0;
        if (clr) begin
            state_n = ST_EMPTY;
            idx_n   = '0;
            len_n   = '0;
        end else begin
            case (state)
                ST_EMPTY, ST_LOAD: begin
                    if (wr_valid) begin
                        wr_en = 1'b1;
                        if (wr_last || idx == LAST_IDX) begin
                            state_n = ST_READY;
                            len_n   = idx + IW'(1);
                            idx_n   = '0;
                        end else begin
                            state_n = ST_LOAD;
                            idx_n   = idx + IW'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (start && !stop) begin
                        state_n = ST_SCROLL;
                        idx_n   = '0;
                        restart = 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        state_n = ST_READY;
                        idx_n   = '0;
                    end else if (tick) begin
                        if (idx == len - IW'(1)) begin
                            idx_n  = '0;
                            wrap_n = 1'b1;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // A write never coincides with entering or staying in SCROLL, so the
    // buffer read below always sees settled contents.
    assign cur_code = msg_buf[idx_n[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg_buf[idx[AW-1:0]] <= alpha_norm(wr_code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            idx      <= '0;
            len      <= '0;
            code_q   <= ALPHA_BLANK;
            blank    <= 1'b1;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            len   <= len_n;
            if (state_n == ST_SCROLL) begin
                code_q <= cur_code;
                blank  <= (cur_code == ALPHA_BLANK);
            end else begin
                code_q <= ALPHA_BLANK;
                blank  <= 1'b1;
            end
            busy     <= (state_n == ST_SCROLL);
            wrap     <= wrap_n;
            wr_ready <= (state_n == ST_EMPTY) || (state_n == ST_LOAD);
        end
    end

    assign {a, b, c, d, e} = code_q;

endmodule

// File: tb/tb_alpha_scroller.sv
module tb_alpha_scroller;

    localparam int TDIV  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] wr_code = 5'd0;
    logic       wr_last = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       a, b, c, d, e;
    logic       blank, busy, wrap;

    alpha_scroller #(.MSG_DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_code  (wr_code),
        .wr_last  (wr_last),
        .start    (start),
        .stop     (stop),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .blank    (blank),
        .busy     (busy),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a message list, whether it is complete, whether it
    // is being shown, which entry is shown and for how many cycles so far.
    int msg[$];
    bit m_loaded    = 1'b0;
    bit m_scrolling = 1'b0;
    int m_pos       = 0;
    int m_age       = 0;
    bit m_wrap      = 1'b0;

    task automatic model_update();
        m_wrap = 1'b0;
        if (rst || clr) begin
            msg.delete();
            m_loaded    = 1'b0;
            m_scrolling = 1'b0;
        end else if (!m_loaded) begin
            if (wr_valid) begin
                msg.push_back((wr_code > 5'd25) ? 31 : int'(wr_code));
                if (wr_last || msg.size() == DEPTH) m_loaded = 1'b1;
            end
        end else if (!m_scrolling) begin
            if (start && !stop) begin
                m_scrolling = 1'b1;
                m_pos       = 0;
                m_age       = 1;
            end
        end else if (stop) begin
            m_scrolling = 1'b0;
        end else if (m_age == TDIV) begin
            m_age  = 1;
            m_pos  = (m_pos + 1) % msg.size();
            m_wrap = (m_pos == 0);
        end else begin
            m_age++;
        end
    endtask

    task automatic step();
        int exp_code;
        @(posedge clk);
        #1;
        model_update();
        exp_code = m_scrolling ? msg[m_pos] : 31;
        check("code",     {a, b, c, d, e}, exp_code);
        check("blank",    blank,    (exp_code == 31) ? 1 : 0);
        check("busy",     busy,     m_scrolling);
        check("wrap",     wrap,     m_wrap);
        check("wr_ready", wr_ready, !m_loaded);
        rst = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        start = 1'b0; stop = 1'b0; wr_code = 5'd0;
    endtask

    task automatic write(input int code, input bit last);
        wr_valid = 1'b1;
        wr_code  = 5'(code);
        wr_last  = last;
        step();
    endtask

    initial begin
        // 1: reset state
        rst = 1'b1;
        step();
        check("rst_code",  {a, b, c, d, e}, 31);
        check("rst_blank", blank, 1);
        check("rst_ready", wr_ready, 1);
        check("rst_busy",  busy, 0);
        check("rst_wrap",  wrap, 0);

        // 2: "HI", hold time and wrap
        write(7, 0);
        write(8, 1);
        start = 1'b1;
        step();
        check("s2_first", {a, b, c, d, e}, 7);
        repeat (3) step();
        check("s2_hold", {a, b, c, d, e}, 7);
        step();
        check("s2_next", {a, b, c, d, e}, 8);
        repeat (4) step();
        check("s2_back", {a, b, c, d, e}, 7);
        check("s2_wrap", wrap, 1);
        step();
        check("s2_wrap_end", wrap, 0);

        // 3: implicit last on full buffer, dropped 5th write
        clr = 1'b1;
        step();
        for (int i = 0; i < 4; i++) write(i, 0);
        check("s3_full_ready", wr_ready, 0);
        write(9, 1);
        start = 1'b1;
        step();
        repeat (17) step();

        // 5: stop two cycles into character 1, restart, start+stop
        stop = 1'b1;
        step();
        start = 1'b1;
        step();
        repeat (5) step();
        stop = 1'b1;
        step();
        check("s5_stop_busy",  busy, 0);
        check("s5_stop_blank", blank, 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("s5_both_busy", busy, 0);
        start = 1'b1;
        step();
        check("s5_restart", {a, b, c, d, e}, 0);
        repeat (3) step();
        check("s5_full_hold", {a, b, c, d, e}, 0);

        // 6a: clr with start during scroll
        clr   = 1'b1;
        start = 1'b1;
        step();
        check("s6_clr_ready", wr_ready, 1);

        // 4: single blank character, wrap every TDIV cycles
        write(27, 1);
        start = 1'b1;
        step();
        check("s4_blank", blank, 1);
        check("s4_busy",  busy, 1);
        repeat (12) step();

        // 6b: reset mid-load discards partial message
        clr = 1'b1;
        step();
        write(5, 0);
        write(6, 0);
        rst = 1'b1;
        step();
        write(2, 1);
        start = 1'b1;
        step();
        check("s6_rst_idx0", {a, b, c, d, e}, 2);
        repeat (6) step();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            clr      = ($urandom_range(0, 149) == 0);
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_code  = 5'($urandom_range(0, 31));
            wr_last  = ($urandom_range(0, 2) == 0);
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
